multi_channel_sync_gen: RTL

Parametrised successor to the single pulse/detector gate generator. It produces a free-running square sync, or follows an external sync, and fans the trigger out to `CHANNELS` independent delay/width gate engines. Delay and width are latched per trigger, and each channel has a sticky overrun flag that records triggers dropped while the channel was busy. It sits between the control register bank and the MZI/detector drive pins.

---
 rtl/multi_channel_sync_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multi_channel_sync_gen.sv
// Sync/trigger generator feeding CHANNELS independent delay/width gate engines.
// Internal square sync or synchronised external sync selects the master edge.

module multi_channel_sync_gen_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] wid,
  input  logic             en,
  input  logic             clr_ovr,
  output logic             gate_o,
  output logic             ovr_o
);
  typedef enum logic [1:0] {IDLE, DELAY, GATE} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, dly_q, wid_q;
  logic             gate_q, ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      gate_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // A trigger arriving while busy is dropped; setting beats a same-edge clear.
      if (trig && state_q != IDLE) ovr_q <= 1'b1;
      else if (clr_ovr)            ovr_q <= 1'b0;

      case (state_q)
        IDLE: if (trig) begin
          dly_q   <= dly;
          wid_q   <= wid;
          cnt_q   <= '0;
          state_q <= DELAY;
        end
        DELAY: if (cnt_q < dly_q) cnt_q <= cnt_q + ONE;
        else begin
          cnt_q   <= '0;
          state_q <= GATE;
        end
        GATE: if (cnt_q < wid_q) begin
          cnt_q  <= cnt_q + ONE;
          gate_q <= en;
        end else begin
          gate_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          gate_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gate_o = gate_q;
  assign ovr_o  = ovr_q;
endmodule

module multi_channel_sync_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CNT_W-1:0]          half_period,
  input  logic                      sync_sel,
  input  logic                      sync_ext,
  input  logic [CHANNELS*CNT_W-1:0] ch_delay,
  input  logic [CHANNELS*CNT_W-1:0] ch_width,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       ch_cw,
  input  logic [CHANNELS-1:0]       clr_overrun,
  output logic                      sync_out,
  output logic                      trig,
  output logic [CHANNELS-1:0]       ch_out,
  output logic [CHANNELS-1:0]       overrun
);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]    sc_q, sc_d;
  logic                sync_out_q, sync_out_d;
  logic                ext_s1_q, ext_s2_q;
  logic                m_q, m_d, m_prev_q;
  logic [CHANNELS-1:0] gate;

  always_comb begin
    sc_d       = sc_q + ONE;
    sync_out_d = sync_out_q;
    // >= keeps the counter bounded if half_period shrinks mid-count
    if (sc_q >= half_period) begin
      sc_d       = '0;
      sync_out_d = ~sync_out_q;
    end
    // Internal master tracks sync_out with no extra lag; external path gains one stage.
    m_d = sync_sel ? sync_out_d : ext_s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q       <= '0;
      sync_out_q <= 1'b0;
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
      m_q        <= 1'b0;
      m_prev_q   <= 1'b0;
    end else begin
      sc_q       <= sc_d;
      sync_out_q <= sync_out_d;
      ext_s1_q   <= sync_ext;
      ext_s2_q   <= ext_s1_q;
      m_q        <= m_d;
      m_prev_q   <= m_q;
    end
  end

  assign sync_out = sync_out_q;
  assign trig     = m_q & ~m_prev_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    multi_channel_sync_gen_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .trig    (trig),
      .dly     (ch_delay[i*CNT_W +: CNT_W]),
      .wid     (ch_width[i*CNT_W +: CNT_W]),
      .en      (ch_en[i]),
      .clr_ovr (clr_overrun[i]),
      .gate_o  (gate[i]),
      .ovr_o   (overrun[i])
    );
  end

  assign ch_out = ch_cw | gate;
endmodule
